// File: rtl/corr_pkg.sv
// Shared definitions for the autocorrelator front end: bit-order selectors and
// the helper that sizes bit-count fields.
package corr_pkg;

  localparam bit ORDER_MSB = 1'b1;
  localparam bit ORDER_LSB = 1'b0;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_word_packer.sv
// Serial-in/parallel-out packer: collects one bit per handshake into WIDTH-bit
// words, with selectable bit order, backpressure, partial flush and overrun flag.
module sipo_word_packer
  import corr_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = ORDER_MSB
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_bit,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [WIDTH-1:0]            out_word,
  output logic [cnt_width(WIDTH)-1:0] out_count,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overrun
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] asm_r, asm_d, asm_ins_s;
  logic [CW-1:0]    cnt_r, cnt_d, cnt_after_s;
  logic             asm_full_r, asm_full_d;
  logic             flush_pend_r, flush_pend_d;
  logic [WIDTH-1:0] out_word_r, out_word_d;
  logic [CW-1:0]    out_count_r, out_count_d;
  logic             out_valid_r, out_valid_d;
  logic             overrun_r, overrun_d;
  logic             accept_s, out_free_s, word_done_s, flush_req_s;

  function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] k);
    if (MSB_FIRST) begin
      bit_pos = LAST - k;
    end else begin
      bit_pos = k;
    end
  endfunction

  // Next-state logic for the assembly register, bit counter and output register.
  always_comb begin
    accept_s    = in_valid && !asm_full_r;
    out_free_s  = !out_valid_r || out_ready;
    asm_ins_s   = asm_r;
    if (accept_s) begin
      asm_ins_s[bit_pos(cnt_r)] = in_bit;
    end else begin
      asm_ins_s = asm_r;
    end
    cnt_after_s = accept_s ? (cnt_r + CW'(1)) : cnt_r;
    word_done_s = accept_s && (cnt_r == LAST);
    // A pending flush is never left behind with an empty assembly register.
    flush_req_s = (flush || flush_pend_r) && !asm_full_r && (cnt_after_s != {CW{1'b0}});

    asm_d        = asm_r;
    cnt_d        = cnt_r;
    asm_full_d   = asm_full_r;
    flush_pend_d = flush_pend_r;
    out_word_d   = out_word_r;
    out_count_d  = out_count_r;
    out_valid_d  = (out_valid_r && out_ready) ? 1'b0 : out_valid_r;
    overrun_d    = overrun_r || (in_valid && asm_full_r);

    if (asm_full_r) begin
      if (out_free_s) begin
        out_word_d   = asm_r;
        out_count_d  = CW'(WIDTH);
        out_valid_d  = 1'b1;
        asm_d        = {WIDTH{1'b0}};
        cnt_d        = {CW{1'b0}};
        asm_full_d   = 1'b0;
        flush_pend_d = 1'b0;
      end else begin
        asm_full_d   = 1'b1;
      end
    end else if (out_free_s && (word_done_s || flush_req_s)) begin
      // cnt_after equals WIDTH on a completed word, so it serves both cases.
      out_word_d   = asm_ins_s;
      out_count_d  = cnt_after_s;
      out_valid_d  = 1'b1;
      asm_d        = {WIDTH{1'b0}};
      cnt_d        = {CW{1'b0}};
      flush_pend_d = 1'b0;
    end else if (word_done_s) begin
      asm_d        = asm_ins_s;
      cnt_d        = {CW{1'b0}};
      asm_full_d   = 1'b1;
      flush_pend_d = 1'b0;
    end else begin
      asm_d        = asm_ins_s;
      cnt_d        = cnt_after_s;
      flush_pend_d = flush_req_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r        <= {WIDTH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      asm_full_r   <= 1'b0;
      flush_pend_r <= 1'b0;
      out_word_r   <= {WIDTH{1'b0}};
      out_count_r  <= {CW{1'b0}};
      out_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      asm_r        <= asm_d;
      cnt_r        <= cnt_d;
      asm_full_r   <= asm_full_d;
      flush_pend_r <= flush_pend_d;
      out_word_r   <= out_word_d;
      out_count_r  <= out_count_d;
      out_valid_r  <= out_valid_d;
      overrun_r    <= overrun_d;
    end
  end

  assign in_ready  = !asm_full_r;
  assign out_word  = out_word_r;
  assign out_count = out_count_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule
